// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Width of one adder slice.
    localparam int NIBBLE_W = 4;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requester (master) and the nibble-serial adder (slave).
//
// Handshake: the master raises start with a, b and cin valid; the request is
// taken on the first rising edge where start=1 and ready=1, and only that edge
// samples the operands. ready is high only while the adder is idle. done is a
// one-cycle pulse marking s, cout and ovf as valid; there is no back-pressure
// on the result. fsm_state mirrors the sequencer state for observation.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    import nibble_serial_adder_pkg::*;

    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic [1:0]   fsm_state;

    modport master (
        output start, a, b, cin,
        input  ready, done, s, cout, ovf, fsm_state
    );

    modport slave (
        input  start, a, b, cin,
        output ready, done, s, cout, ovf, fsm_state
    );

endinterface

// File: rtl/ripple_carry_adder.sv
// One 4-bit ripple-carry slice: s/cout = a + b + cin.
module ripple_carry_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    // Full-adder chain, carry rippling from bit 0 upward.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit slice, one nibble per clock, LSB nibble first.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    nibble_serial_adder_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state;
    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic                 carry;
    logic [IDX_W-1:0]     idx;
    logic [W-1:0]         s_reg;
    logic                 cout_reg;
    logic                 ovf_reg;

    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  sum_nib;
    logic                 c_nib;

    // Present the current nibble pair to the slice; operands come only from
    // the captured registers, so no input reaches an output combinationally.
    always_comb begin
        a_nib = a_reg[NIBBLE_W*idx +: NIBBLE_W];
        b_nib = b_reg[NIBBLE_W*idx +: NIBBLE_W];
    end

    ripple_carry_adder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (sum_nib),
        .cout (c_nib)
    );

    // Sequencer: capture on accept, one nibble per RUN edge, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_reg[NIBBLE_W*idx +: NIBBLE_W] <= sum_nib;
                    carry <= c_nib;
                    if (idx == LAST_IDX) begin
                        cout_reg <= c_nib;
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (sum_nib[NIBBLE_W-1] != a_reg[W-1]);
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status decoded straight from the state register; results are registers.
    always_comb begin
        bus.ready     = (state == ST_IDLE);
        bus.done      = (state == ST_DONE);
        bus.s         = s_reg;
        bus.cout      = cout_reg;
        bus.ovf       = ovf_reg;
        bus.fsm_state = state;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vectors, a queued-start run and a
// long randomised run, checked against a transaction-level model every cycle.
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A request is taken at edge e when no operation is in flight; its result
    // appears NIBBLES edges later and the block is idle again one edge after.
    int              cyc       = -1;
    int              next_free = 0;
    int              done_at   = -1;
    logic [W+1:0]    exp_q[$];
    logic [W-1:0]    held_s    = '0;
    logic            held_cout = 1'b0;
    logic            held_ovf  = 1'b0;
    logic [W:0]      m_sum;
    logic            m_ovf;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            next_free = cyc + 1;
            done_at   = -1;
            held_s    = '0;
            held_cout = 1'b0;
            held_ovf  = 1'b0;
        end else if (cyc >= next_free && bus.start === 1'b1) begin
            m_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
            m_ovf = (bus.a[W-1] == bus.b[W-1]) && (m_sum[W-1] != bus.a[W-1]);
            exp_q.push_back({m_ovf, m_sum});
            done_at   = cyc + NIBBLES;
            next_free = cyc + NIBBLES + 2;
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [W+1:0] e;
    always @(negedge clk) begin
        if (cyc >= 0) begin
            check("ready", {31'b0, bus.ready}, {31'b0, (cyc + 1 >= next_free)});
            check("done", {31'b0, bus.done}, {31'b0, (cyc == done_at)});
            if (cyc == done_at) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_empty: done with no expected result (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_s", {16'b0, bus.s}, {16'b0, e[W-1:0]});
                    check("sb_cout", {31'b0, bus.cout}, {31'b0, e[W]});
                    check("sb_ovf", {31'b0, bus.ovf}, {31'b0, e[W+1]});
                    held_s    = e[W-1:0];
                    held_cout = e[W];
                    held_ovf  = e[W+1];
                end
            end else if (cyc + 1 >= next_free) begin
                check("hold_s", {16'b0, bus.s}, {16'b0, held_s});
                check("hold_cout", {31'b0, bus.cout}, {31'b0, held_cout});
                check("hold_ovf", {31'b0, bus.ovf}, {31'b0, held_ovf});
            end
        end
    end

    // Observed result pulses, for the literal checks below.
    logic [W-1:0] obs_s[$];
    logic         obs_cout[$];
    logic         obs_ovf[$];
    int           obs_cyc[$];

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            obs_s.push_back(bus.s);
            obs_cout.push_back(bus.cout);
            obs_ovf.push_back(bus.ovf);
            obs_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs_clear();
        obs_s.delete();
        obs_cout.delete();
        obs_ovf.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_obs(input int n, input string tag);
        int waited = 0;
        while (obs_s.size() < n && waited < 40) begin
            tick();
            waited++;
        end
        if (obs_s.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: saw %0d done pulses expected %0d", tag, obs_s.size(), n);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string tag);
        int acc;
        obs_clear();
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        tick();
        acc = cyc;
        bus.start = 1'b0;
        wait_obs(1, tag);
        if (obs_s.size() >= 1) begin
            check({tag, "_s"}, {16'b0, obs_s[0]}, {16'b0, es});
            check({tag, "_cout"}, {31'b0, obs_cout[0]}, {31'b0, ec});
            check({tag, "_ovf"}, {31'b0, obs_ovf[0]}, {31'b0, eo});
            check({tag, "_latency"}, obs_cyc[0] - acc, NIBBLES);
        end
        tick();
        check({tag, "_pulses"}, obs_s.size(), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Reset state.
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_s", {16'b0, bus.s}, 32'd0);
        check("rst_cout", {31'b0, bus.cout}, 32'd0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'd0);

        // Directed arithmetic vectors.
        run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");

        // cin only, with start pulses during RUN and DONE that must be ignored.
        obs_clear();
        bus.a = 16'h0000; bus.b = 16'h0000; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        acc = cyc;
        bus.start = 1'b0;
        tick();
        bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < acc + NIBBLES) tick();
        bus.a = 16'h5555; bus.b = 16'h3333; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_obs(1, "ignore");
        if (obs_s.size() >= 1) check("ignore_s", {16'b0, obs_s[0]}, 32'h0001);
        tick();
        check("ignore_hold_s", {16'b0, bus.s}, 32'h0001);
        check("ignore_pulses", obs_s.size(), 1);

        // Reset in the second RUN cycle aborts the operation.
        obs_clear();
        bus.a = 16'hABCD; bus.b = 16'h1357; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {31'b0, bus.ready}, 32'd1);
        check("abort_s", {16'b0, bus.s}, 32'd0);
        repeat (8) tick();
        check("abort_no_done", obs_s.size(), 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "after_abort");

        // start held high with three operand sets.
        obs_clear();
        bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        acc = cyc;
        repeat (5) tick();
        bus.a = 16'h1000; bus.b = 16'h2000; bus.cin = 1'b1;
        repeat (6) tick();
        bus.a = 16'hF0F0; bus.b = 16'h0F10; bus.cin = 1'b0;
        repeat (6) tick();
        bus.start = 1'b0;
        wait_obs(3, "queued");
        if (obs_s.size() >= 3) begin
            check("queued0_s", {16'b0, obs_s[0]}, 32'h0003);
            check("queued1_s", {16'b0, obs_s[1]}, 32'h3001);
            check("queued2_s", {16'b0, obs_s[2]}, 32'h0000);
            check("queued2_cout", {31'b0, obs_cout[2]}, 32'd1);
            check("queued_lat", obs_cyc[0] - acc, NIBBLES);
            check("queued_gap01", obs_cyc[1] - obs_cyc[0], NIBBLES + 2);
            check("queued_gap12", obs_cyc[2] - obs_cyc[1], NIBBLES + 2);
        end
        repeat (4) tick();

        // Randomised run: start held high, operands changing every cycle.
        bus.start = 1'b1;
        repeat (1000 * (NIBBLES + 2)) begin
            bus.a   = W'($urandom_range(0, (1 << W) - 1));
            bus.b   = W'($urandom_range(0, (1 << W) - 1));
            bus.cin = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        repeat (NIBBLES + 4) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder that feeds one 4-bit `ripple_carry_adder` slice per clock. It adds two NIBBLES×4-bit operands least-significant nibble first, carrying between nibbles in a register. It sits directly upstream of the 4-bit adder: it captures wide operands, presents one nibble pair plus carry per cycle, and assembles the slice outputs into the wide result. A start/ready/done handshake frames each operation.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4×NIBBLES; legal range ≥ 2.
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- start  input  1  request; accepted only when ready=1.
- a  input  W  operand A, sampled on the accepting edge only.
- b  input  W  operand B, sampled on the accepting edge only.
- cin  input  1  carry-in to nibble 0, sampled on the accepting edge only.
- ready  output  1  high only in IDLE; decoded directly from state.
- done  output  1  single-cycle pulse; result valid.
- s  output  W  sum; registered.
- cout  output  1  carry out of the top nibble; registered.
- ovf  output  1  two's-complement overflow; registered.

## Operation
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE: ready=1.
  - On an edge with start=1: latch a, b and cin into operand registers; carry register ← cin; idx ← 0; go to RUN.
  - start=0 holds IDLE.
- RUN: the slice adds a_reg[4·idx+3:4·idx], b_reg nibble idx and the carry register.
  - Each edge: s[4·idx+3:4·idx] ← slice sum; carry ← slice cout; idx ← idx+1.
  - On the edge where idx = NIBBLES−1: cout ← slice cout; ovf ← (a_reg[W−1] == b_reg[W−1]) && (slice sum bit 3 != a_reg[W−1]); go to DONE.
- DONE: done=1 for exactly this cycle; ready=0; next edge returns to IDLE unconditionally.
- start while RUN or DONE is ignored. It is not queued, and operands are not resampled.
- s, cout and ovf hold their values from DONE until the next accepted start.
  - After an accepted start, s updates nibble by nibble during RUN.
  - Consumers read s, cout and ovf only when done=1.
- Arithmetic is unsigned modulo 2^W; cout is the true bit W. ovf flags signed overflow of the W-bit sum and ignores cin in its sign rule.
- idx width: clog2(NIBBLES); idx never wraps past NIBBLES−1.

## Timing
- Reset values: state=IDLE, ready=1, done=0, s=0, cout=0, ovf=0, carry=0, idx=0, operand registers=0.
- rst has priority over every other input, including in the same cycle as start.
- rst mid-RUN or in DONE aborts the operation: no done pulse, outputs zeroed, ready=1 the cycle after the reset edge.
- Latency: start accepted at edge 0 → RUN during cycles 1…NIBBLES → done high in cycle NIBBLES+1. With NIBBLES=4, done is high in the 5th cycle after acceptance.
- Throughput: one operation per NIBBLES+2 cycles. With start held high continuously, acceptances occur every NIBBLES+2 edges.
- The critical path is one 4-bit ripple plus register setup. There is no combinational path from a, b or start to any output.

## Structure
- Shared package/header:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_DONE=2;
  - NIBBLE_W=4.
- One sub-module: a single instance of the existing `ripple_carry_adder` (ports a, b, cin, s, cout), driven by the muxed operand nibbles and the carry register.
- All remaining logic is local to this block: FSM, idx counter, operand registers, output assembly.

## Test plan
All scenarios use NIBBLES=4.
- a=16'h1234, b=16'h1111, cin=0 → s=16'h2345, cout=0, ovf=0; done exactly 5 cycles after acceptance, high for 1 cycle.
- a=16'hFFFF, b=16'h0001, cin=0 → s=16'h0000, cout=1, ovf=0; carry ripples through all 4 nibbles.
- a=16'h7FFF, b=16'h0001, cin=0 → s=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h8000 → s=0, cout=1, ovf=1.
- a=0, b=0, cin=1 → s=16'h0001. Pulse start with different operands during RUN and DONE → ignored; result unchanged.
- rst asserted in the 2nd RUN cycle → next cycle ready=1, s=0, no done pulse. A following a=16'h00FF, b=16'h0001 → s=16'h0100.
- start held high with 3 queued operand sets → acceptances 6 cycles apart, each done carries the matching sum. A random 1000-op run matches a+b+cin against a reference model.
